// File: rtl/dct_coef_bridge.sv
// rtl/dct_coef_bridge.sv - DCT->IDCT coefficient requantizer with ping-pong block buffer
//
// Purpose:
//   Captures BLK-word coefficient bursts from the DCT, requantizes each word to
//   OUT_W bits (truncate or round-half-up with saturation), stores them in one of
//   two banks and replays each completed block to the IDCT with a start/reading
//   handshake. Also drives the IDCT approximate-precision enable from a
//   saturating cycle counter window.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   in_valid     level-high while a DCT block streams in
//   in_data      DCT coefficient, sampled each in_valid cycle
//   out_reading  IDCT consumes out_data this cycle
//   out_start    block available and streaming
//   out_data     requantized coefficient, sign-extended to DW
//   rapx         approximate-precision enable
//   blk_count    blocks fully delivered (wraps)
//   overflow     sticky: a block was dropped because both banks were full

module dct_coef_bridge #(
    parameter int DW        = 32,
    parameter int OUT_W     = 12,
    parameter int ROUND     = 0,
    parameter int BLK       = 64,
    parameter int APX_START = 500000,
    parameter int APX_END   = 1000000,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    input  logic              out_reading,
    output logic              out_start,
    output logic [DW-1:0]     out_data,
    output logic              rapx,
    output logic [15:0]       blk_count,
    output logic              overflow
);

    localparam int              PW   = (BLK > 1) ? $clog2(BLK) : 1;
    localparam logic [PW-1:0]   LAST = PW'(BLK - 1);
    localparam logic [OUT_W-1:0] QMAX = {OUT_W{1'b1}} >> 1;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_STREAM, R_GAP} rstate_t;

    logic [OUT_W-1:0] r_mem0 [BLK];
    logic [OUT_W-1:0] r_mem1 [BLK];

    wstate_t          r_wstate, w_wstate_nxt;
    rstate_t          r_rstate, w_rstate_nxt;
    logic             r_wbank, r_rbank;
    logic [PW-1:0]    r_wptr, w_wptr_nxt;
    logic [PW-1:0]    r_rptr, w_rptr_nxt;
    logic [1:0]       r_full, w_full_nxt;
    logic             w_we, w_fill_done, w_ovf_set, w_rd_done;
    logic [15:0]      r_blk_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rapx;

    logic [OUT_W-1:0] w_q_trunc, w_q;
    logic             w_rbit;
    logic [OUT_W-1:0] w_rword;
    logic             w_unused;

    // Requantize at write time so each bank entry only holds OUT_W bits.
    assign w_q_trunc = in_data[DW-1 -: OUT_W];
    assign w_rbit    = (ROUND != 0) ? in_data[DW-OUT_W-1] : 1'b0;
    // Rounding up the largest positive code would wrap to the most negative one.
    assign w_q       = (w_rbit && (w_q_trunc != QMAX)) ? (w_q_trunc + OUT_W'(1)) : w_q_trunc;
    assign w_unused  = &{1'b0, in_data};

    // Write FSM: the write pointer is always 0 in W_IDLE, so word 0 shares the fill path.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wptr_nxt   = r_wptr;
        w_we         = 1'b0;
        w_fill_done  = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_wstate)
            W_IDLE, W_FILL: begin
                if (in_valid && (r_wstate == W_FILL || !r_full[r_wbank])) begin
                    w_we = 1'b1;
                    if (r_wptr == LAST) begin
                        w_fill_done  = 1'b1;
                        w_wptr_nxt   = '0;
                        w_wstate_nxt = W_WAIT;
                    end else begin
                        w_wptr_nxt   = r_wptr + PW'(1);
                        w_wstate_nxt = W_FILL;
                    end
                end else if (in_valid) begin
                    // Strict ping-pong: the current write bank being full means both are.
                    w_ovf_set    = 1'b1;
                    w_wstate_nxt = W_WAIT;
                end else if (r_wstate == W_FILL) begin
                    // Short burst: the bank is simply never marked full.
                    w_wptr_nxt   = '0;
                    w_wstate_nxt = W_IDLE;
                end
            end
            W_WAIT: begin
                if (!in_valid) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read FSM
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rptr_nxt   = r_rptr;
        w_rd_done    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_rptr_nxt   = '0;
                    w_rstate_nxt = R_STREAM;
                end
            end
            R_STREAM: begin
                if (out_reading) begin
                    if (r_rptr == LAST) begin
                        w_rd_done    = 1'b1;
                        w_rptr_nxt   = '0;
                        w_rstate_nxt = R_GAP;
                    end else begin
                        w_rptr_nxt   = r_rptr + PW'(1);
                    end
                end
            end
            R_GAP: begin
                // Going straight back to R_STREAM keeps the low pulse to one cycle.
                w_rptr_nxt   = '0;
                w_rstate_nxt = r_full[r_rbank] ? R_STREAM : R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Fill and release always target different banks, so both can land in one cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_done)   w_full_nxt[r_rbank] = 1'b0;
        if (w_fill_done) w_full_nxt[r_wbank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wstate    <= W_IDLE;
            r_rstate    <= R_IDLE;
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_full      <= 2'b00;
            r_blk_count <= '0;
            r_overflow  <= 1'b0;
            r_cnt       <= '0;
            r_rapx      <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_full   <= w_full_nxt;
            if (w_fill_done) r_wbank <= ~r_wbank;
            if (w_rd_done) begin
                r_rbank     <= ~r_rbank;
                r_blk_count <= r_blk_count + 16'd1;
            end
            if (w_ovf_set) r_overflow <= 1'b1;
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
            r_rapx <= (r_cnt > CNT_W'(APX_START)) && (r_cnt < CNT_W'(APX_END));
        end
    end

    // Bank storage needs no reset: contents are only visible behind a full flag.
    always_ff @(posedge clk) begin
        if (reset && w_we) begin
            if (r_wbank) r_mem1[r_wptr] <= w_q;
            else         r_mem0[r_wptr] <= w_q;
        end
    end

    assign w_rword   = r_rbank ? r_mem1[r_rptr] : r_mem0[r_rptr];
    assign out_start = (r_rstate == R_STREAM);
    assign out_data  = out_start ? {{(DW-OUT_W){w_rword[OUT_W-1]}}, w_rword} : '0;
    assign rapx      = r_rapx;
    assign blk_count = r_blk_count;
    assign overflow  = r_overflow;

endmodule
